// File: rtl/mm_sequencer.sv
// mm_sequencer: control FSM walking the 2x2 matrix-multiply product terms, then driving accumulation and result capture
module mm_sequencer #(
  parameter int N           = 2,
  parameter int IDX_W       = 2,
  parameter int PADDR_W     = 3,
  parameter int CNT_W       = 8,
  parameter int ADD_TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               add_done,
  output logic [IDX_W-1:0]   a_sel,
  output logic [IDX_W-1:0]   b_sel,
  output logic               prod_we,
  output logic [PADDR_W-1:0] prod_addr,
  output logic               add_start,
  output logic               result_we,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [CNT_W-1:0]   matrix_count
);
  localparam int TW = $clog2(ADD_TIMEOUT + 1);
  localparam logic [PADDR_W-1:0] LAST = PADDR_W'(N * N * N - 1);
  localparam logic [TW-1:0] T_LAST = TW'(ADD_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT_ADD, WRITE} state_t;
  state_t             state_q, state_d;
  logic [PADDR_W-1:0] p_q, p_d;
  logic [TW-1:0]      t_q, t_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   count_q, count_d;
  // state, product index, wait timer, sticky error and completion counter
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      t_q     <= '0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      t_q     <= t_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  // next-state logic; outputs decode from registered state so they stay aligned with prod_we
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    t_d     = t_q;
    error_d = error_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        p_d     = '0;
        error_d = 1'b0;
      end
      LOAD: begin
        p_d     = p_q + 1'b1;
        state_d = (p_q == LAST) ? KICK : LOAD;
      end
      KICK: begin
        t_d     = '0;
        state_d = WAIT_ADD;
      end
      WAIT_ADD: if (add_done) state_d = WRITE;
        else if (t_q == T_LAST) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else t_d = t_q + 1'b1;
      WRITE: begin
        count_d = count_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    prod_we      = state_q == LOAD;
    prod_addr    = prod_we ? p_q : '0;
    a_sel        = prod_we ? IDX_W'((int'(p_q) / (N * N)) * N + int'(p_q) % N) : '0;
    b_sel        = prod_we ? IDX_W'((int'(p_q) % N) * N + (int'(p_q) / N) % N) : '0;
    add_start    = state_q == KICK;
    result_we    = state_q == WRITE;
    done         = state_q == WRITE;
    busy         = state_q != IDLE;
    error        = error_q;
    matrix_count = count_q;
  end
endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer: directed stimulus with a cycle-count reference model and literal pins
module tb_mm_sequencer;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, add_done = 1'b0;
  logic [1:0] a_sel, b_sel;
  logic [2:0] prod_addr;
  logic prod_we, add_start, result_we, busy, done, error;
  logic [7:0] matrix_count;
  mm_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .add_done(add_done),
    .a_sel(a_sel), .b_sel(b_sel), .prod_we(prod_we), .prod_addr(prod_addr),
    .add_start(add_start), .result_we(result_we), .busy(busy), .done(done),
    .error(error), .matrix_count(matrix_count)
  );
  always #5 clock = ~clock;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  // reference: m_r = cycles since the start-sample edge; LOAD is 1..8, KICK is 9, waiting from 10
  int m_r = 0;
  logic m_wr = 1'b0, m_err = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  always @(posedge clock or negedge reset)
    if (!reset) begin
      m_r <= 0; m_wr <= 1'b0; m_err <= 1'b0; m_cnt <= 8'd0;
    end else if (m_r == 0) begin
      if (start) begin m_r <= 1; m_err <= 1'b0; end
    end else if (m_wr) begin
      m_r <= 0; m_wr <= 1'b0; m_cnt <= m_cnt + 8'd1;
    end else if (m_r < 10) m_r <= m_r + 1;
    else if (add_done) begin m_wr <= 1'b1; m_r <= m_r + 1; end
    else if (m_r == 9 + 15) begin m_r <= 0; m_err <= 1'b1; end
    else m_r <= m_r + 1;
  always @(negedge clock) begin : cmp
    int p;
    logic ld;
    p  = m_r - 1;
    ld = m_r >= 1 && m_r <= 8;
    chk("busy", busy, m_r != 0);
    chk("prod_we", prod_we, ld);
    chk("prod_addr", prod_addr, ld ? p : 0);
    chk("a_sel", a_sel, ld ? (p / 4) * 2 + p % 2 : 0);
    chk("b_sel", b_sel, ld ? (p % 2) * 2 + (p / 2) % 2 : 0);
    chk("add_start", add_start, m_r == 9);
    chk("done", done, m_wr);
    chk("result_we", result_we, m_wr);
    chk("error", error, m_err);
    chk("matrix_count", matrix_count, m_cnt);
  end
  int done_cnt = 0, ks_cnt = 0, last_done = 0, prev_done = 0, s_cyc = 0;
  logic [6:0] lq[$];
  always @(negedge clock) begin
    if (done) begin done_cnt <= done_cnt + 1; prev_done <= last_done; last_done <= cyc; end
    if (add_start) ks_cnt <= ks_cnt + 1;
    if (prod_we) lq.push_back({prod_addr, a_sel, b_sel});
  end
  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clock); #1; end
  endtask
  task automatic pulse_start();
    s_cyc = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin tick(); k++; end
    chk("reach_idle", busy, 0);
  endtask
  task automatic check_load();
    int ea[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int eb[8] = '{0, 2, 1, 3, 0, 2, 1, 3};
    chk("load_len", lq.size(), 8);
    for (int i = 0; i < 8 && i < lq.size(); i++) begin
      chk("load_addr", lq[i][6:4], i);
      chk("load_a", lq[i][3:2], ea[i]);
      chk("load_b", lq[i][1:0], eb[i]);
    end
  endtask
  initial begin
    int d0, k0, k;
    tick(3);
    reset = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_count", matrix_count, 0);
    chk("rst_outs", {prod_we, add_start, result_we, done, error, a_sel, b_sel, prod_addr}, 0);
    add_done = 1'b1;
    lq.delete();
    pulse_start();
    wait_idle(40);
    check_load();
    chk("t2_kicks", ks_cnt, 1);
    chk("t2_latency", last_done - s_cyc + 1, 11);
    chk("t2_count", matrix_count, 1);
    add_done = 1'b0;
    k0 = ks_cnt;
    pulse_start();
    k = 0;
    while (!add_start && k < 20) begin tick(); k++; end
    chk("t3_kick_seen", add_start, 1);
    tick(5);
    add_done = 1'b1;
    wait_idle(40);
    add_done = 1'b0;
    chk("t3_kicks", ks_cnt - k0, 1);
    chk("t3_latency", last_done - s_cyc + 1, 15);
    chk("t3_count", matrix_count, 2);
    d0 = done_cnt;
    pulse_start();
    tick(30);
    chk("t4_error", error, 1);
    chk("t4_no_done", done_cnt, d0);
    chk("t4_count", matrix_count, 2);
    add_done = 1'b1;
    pulse_start();
    chk("t4_err_clear", error, 0);
    wait_idle(40);
    chk("t4_count_after", matrix_count, 3);
    add_done = 1'b0;
    d0 = done_cnt;
    k0 = ks_cnt;
    pulse_start();
    tick(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!add_start && k < 20) begin tick(); k++; end
    tick(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    add_done = 1'b1;
    wait_idle(40);
    chk("t5_kicks", ks_cnt - k0, 1);
    chk("t5_dones", done_cnt - d0, 1);
    chk("t5_count", matrix_count, 4);
    start = 1'b1;
    k = 0;
    while (matrix_count != 8'd255 && k < 4000) begin tick(); k++; end
    chk("t5_reach_255", matrix_count, 255);
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 30) begin tick(); k++; end
    chk("t5_gap", last_done - prev_done, 12);
    tick();
    chk("t5_wrap", matrix_count, 0);
    start = 1'b0;
    wait_idle(40);
    d0 = done_cnt;
    pulse_start();
    k = 0;
    while (!(prod_we && prod_addr == 3'd4) && k < 20) begin tick(); k++; end
    chk("t6_at_p4", prod_addr, 4);
    #1 reset = 1'b0;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_outs", {prod_we, add_start, result_we, done, a_sel, b_sel, prod_addr}, 0);
    chk("t6_async_count", matrix_count, 0);
    tick(3);
    reset = 1'b1;
    tick();
    chk("t6_no_done", done_cnt, d0);
    lq.delete();
    pulse_start();
    wait_idle(40);
    check_load();
    chk("t6_count", matrix_count, 1);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
